// File: rtl/bn128_pkg.sv
// bn128 base-field constants and behavioural helpers shared by the Montgomery blocks and their benches.
// The fe_* functions use wide '%' and are meant for reference models, not for the datapath.
package bn128_pkg;

    localparam int unsigned FE_BITS          = 256;
    localparam int unsigned MONT_REDUCE_BITS = 256;

    localparam logic [FE_BITS-1:0] P =
        256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;
    // R = 2^MONT_REDUCE_BITS reduced mod P, and R^2 mod P.
    localparam logic [FE_BITS-1:0] MONT_R_MODP =
        256'h0e0a77c19a07df2f666ea36f7879462c0a78eb28f5c70b3dd35d438dc58f0d9d;
    localparam logic [FE_BITS-1:0] MONT_R2_MODP =
        256'h06d89f71cab8351f47ab1eff0a417ff6b5e71911d44501fbf32cfc5b538afa89;

    function automatic logic [FE_BITS-1:0] fe_mul(input logic [FE_BITS-1:0] a,
                                                  input logic [FE_BITS-1:0] b);
        logic [2*FE_BITS-1:0] prod;
        prod = {{FE_BITS{1'b0}}, a} * {{FE_BITS{1'b0}}, b};
        prod = prod % {{FE_BITS{1'b0}}, P};
        return prod[FE_BITS-1:0];
    endfunction

    function automatic logic [FE_BITS-1:0] fe_pow(input logic [FE_BITS-1:0] base,
                                                  input logic [FE_BITS-1:0] e);
        logic [FE_BITS-1:0] acc;
        acc = {{(FE_BITS-1){1'b0}}, 1'b1};
        for (int i = FE_BITS - 1; i >= 0; i--) begin
            acc = fe_mul(acc, acc);
            if (e[i]) acc = fe_mul(acc, base);
        end
        return acc;
    endfunction

    // a * R^-1 mod P, with R^-1 obtained from Fermat's little theorem.
    function automatic logic [FE_BITS-1:0] fe_from_mont(input logic [FE_BITS-1:0] a);
        return fe_mul(a % P, fe_pow(MONT_R_MODP, P - 256'd2));
    endfunction

endpackage

// File: rtl/if_axi_stream.sv
// Minimal valid/ready stream bundle with sideband ctl and framing bits.
interface if_axi_stream #(
    parameter int unsigned DAT_BITS = 256,
    parameter int unsigned CTL_BITS = 8
) ();
    logic                val;
    logic                rdy;
    logic [DAT_BITS-1:0] dat;
    logic [CTL_BITS-1:0] ctl;
    logic                sop;
    logic                eop;
    logic                err;

    modport source (output val, dat, ctl, sop, eop, err, input rdy);
    modport sink   (input val, dat, ctl, sop, eop, err, output rdy);
endinterface

// File: rtl/mont_redc_step.sv
// Combinational REDC halving: STEPS iterations of t = (t + (t odd ? MOD : 0)) / 2.
// The caller sizes W so that t + MOD never overflows.
module mont_redc_step #(
    parameter int unsigned  W     = 257,
    parameter int unsigned  STEPS = 1,
    parameter logic [W-1:0] MOD   = '0
) (
    input  logic [W-1:0] t_i,
    output logic [W-1:0] t_o
);
    always_comb begin
        // NOTE: t_o takes a value before the loop, so no path leaves it unassigned (no latch);
        // blocking updates let each sub-step see the previous one within the same evaluation.
        t_o = t_i;
        for (int s = 0; s < int'(STEPS); s++) begin
            t_o = (t_o + (t_o[0] ? MOD : '0)) >> 1;
        end
    end
endmodule

// File: rtl/mont_from_serial.sv
// Bit-serial Montgomery decode: o = a * 2^-REDUCE_BITS mod P via iterative REDC halving,
// one operand in flight, BITS_PER_CYC halvings per clock, final conditional subtract.
module mont_from_serial #(
    parameter int unsigned         DAT_BITS     = 256,
    parameter int unsigned         CTL_BITS     = 8,
    parameter int unsigned         REDUCE_BITS  = bn128_pkg::MONT_REDUCE_BITS,
    parameter logic [DAT_BITS-1:0] P            = bn128_pkg::P,
    parameter int unsigned         BITS_PER_CYC = 1
) (
    input logic          i_clk,
    input logic          i_rst_n,
    if_axi_stream.sink   i_from_mont_if,
    if_axi_stream.source o_from_mont_if
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FIX, ST_OUT} state_e;

    // One spare bit keeps t + P in range for any input below 2^DAT_BITS.
    localparam int unsigned         T_BITS   = DAT_BITS + 1;
    localparam int unsigned         CNT_BITS = $clog2(REDUCE_BITS + 1);
    localparam logic [CNT_BITS-1:0] CNT_STEP = CNT_BITS'(BITS_PER_CYC);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(REDUCE_BITS - BITS_PER_CYC);
    localparam logic [T_BITS-1:0]   P_EXT    = {1'b0, P};

    state_e              state_q, state_d;
    logic [T_BITS-1:0]   t_q, t_d, t_step;
    logic [DAT_BITS-1:0] t_sub;
    logic [CNT_BITS-1:0] cnt_q, cnt_d;
    logic [CTL_BITS-1:0] ctl_q, ctl_d;
    logic                err_q, err_d;
    logic [DAT_BITS-1:0] dat_q, dat_d;
    logic                val_q, val_d;
    logic                rdy_q, rdy_d;
    logic                in_fire, out_fire;
    logic                unused_framing;

    assign in_fire        = i_from_mont_if.val && rdy_q;
    assign out_fire       = val_q && o_from_mont_if.rdy;
    assign unused_framing = i_from_mont_if.sop ^ i_from_mont_if.eop;

    mont_redc_step #(
        .W     (T_BITS),
        .STEPS (BITS_PER_CYC),
        .MOD   (P_EXT)
    ) u_redc_step (
        .t_i (t_q),
        .t_o (t_step)
    );

    // Only used when t >= P, where the difference always fits in DAT_BITS.
    assign t_sub = t_q[DAT_BITS-1:0] - P;

    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        cnt_d   = cnt_q;
        ctl_d   = ctl_q;
        err_d   = err_q;
        dat_d   = dat_q;
        val_d   = val_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_fire) begin
                    t_d     = {1'b0, i_from_mont_if.dat};
                    ctl_d   = i_from_mont_if.ctl;
                    err_d   = i_from_mont_if.err | (i_from_mont_if.dat >= P);
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                t_d   = t_step;
                cnt_d = cnt_q + CNT_STEP;
                if (cnt_q == CNT_LAST) state_d = ST_FIX;
            end
            ST_FIX: begin
                dat_d   = (t_q >= P_EXT) ? t_sub : t_q[DAT_BITS-1:0];
                val_d   = 1'b1;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                if (out_fire) begin
                    val_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        rdy_d = (state_d == ST_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    // The wide t_q/dat_q registers are reset too: cheap here and keeps o.dat at 0 out of reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
            t_q     <= '0;
            cnt_q   <= '0;
            ctl_q   <= '0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            val_q   <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            cnt_q   <= cnt_d;
            ctl_q   <= ctl_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
            val_q   <= val_d;
            rdy_q   <= rdy_d;
        end
    end

    assign i_from_mont_if.rdy = rdy_q;
    assign o_from_mont_if.val = val_q;
    assign o_from_mont_if.dat = dat_q;
    assign o_from_mont_if.ctl = ctl_q;
    assign o_from_mont_if.err = err_q;
    assign o_from_mont_if.sop = val_q;
    assign o_from_mont_if.eop = val_q;
endmodule

// File: tb/tb_mont_from_serial.sv
// Bench for mont_from_serial: instances with 1, 2 and 4 halvings per clock run the same vectors
// side by side; expected results come from the Fermat-inverse model fe_from_mont().
module tb_mont_from_serial;
    import bn128_pkg::*;

    localparam int LANES  = 3;
    localparam int N_RAND = 100;

    typedef struct packed {
        logic [255:0] a;
        logic [7:0]   ctl;
        logic         err_in;
        logic [255:0] exp_dat;
        logic         exp_err;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    logic [LANES-1:0]        in_val, in_err, in_rdy;
    logic [LANES-1:0][255:0] in_dat;
    logic [LANES-1:0][7:0]   in_ctl;
    logic [LANES-1:0]        out_val, out_rdy, out_sop, out_eop, out_err;
    logic [LANES-1:0][255:0] out_dat;
    logic [LANES-1:0][7:0]   out_ctl;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        if_axi_stream #(.DAT_BITS(256), .CTL_BITS(8)) in_if ();
        if_axi_stream #(.DAT_BITS(256), .CTL_BITS(8)) out_if ();

        assign in_if.val   = in_val[g];
        assign in_if.dat   = in_dat[g];
        assign in_if.ctl   = in_ctl[g];
        assign in_if.err   = in_err[g];
        assign in_if.sop   = 1'b1;
        assign in_if.eop   = 1'b1;
        assign in_rdy[g]   = in_if.rdy;
        assign out_if.rdy  = out_rdy[g];
        assign out_val[g]  = out_if.val;
        assign out_dat[g]  = out_if.dat;
        assign out_ctl[g]  = out_if.ctl;
        assign out_err[g]  = out_if.err;
        assign out_sop[g]  = out_if.sop;
        assign out_eop[g]  = out_if.eop;

        mont_from_serial #(
            .DAT_BITS     (256),
            .CTL_BITS     (8),
            .REDUCE_BITS  (256),
            .P            (bn128_pkg::P),
            .BITS_PER_CYC (1 << g)
        ) dut (
            .i_clk          (clk),
            .i_rst_n        (rst_n),
            .i_from_mont_if (in_if),
            .o_from_mont_if (out_if)
        );
    end

    task automatic check(input string name, input int lane, input logic [255:0] act,
                         input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (lane %0d, %0d steps/clk): got %h, want %h",
                     name, lane, 1 << lane, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [255:0] a, input logic [7:0] ctl, input logic err_in,
                                input logic [255:0] exp_dat, input logic exp_err);
        vec_t v;
        v.a       = a;
        v.ctl     = ctl;
        v.err_in  = err_in;
        v.exp_dat = exp_dat;
        v.exp_err = exp_err;
        return v;
    endfunction

    // One full transaction on one lane: handshake in, latency, output fields, backpressure, release.
    task automatic run_op(input int lane, input vec_t v, input bit rand_rdy, input string tag);
        int k;
        bit r;
        bit done;
        @(negedge clk);
        k = 0;
        while (!in_rdy[lane] && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_in_rdy"}, lane, in_rdy[lane], 1'b1);
        in_val[lane]  = 1'b1;
        in_dat[lane]  = v.a;
        in_ctl[lane]  = v.ctl;
        in_err[lane]  = v.err_in;
        out_rdy[lane] = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        @(negedge clk);
        in_val[lane] = 1'b0;
        in_dat[lane] = '0;
        in_ctl[lane] = '0;
        in_err[lane] = 1'b0;
        check({tag, "_busy"}, lane, in_rdy[lane], 1'b0);
        k = 0;
        while (!out_val[lane] && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_latency"}, lane, k, 256 / (1 << lane) + 1);
        check({tag, "_dat"}, lane, out_dat[lane], v.exp_dat);
        check({tag, "_ctl"}, lane, out_ctl[lane], v.ctl);
        check({tag, "_err"}, lane, out_err[lane], v.exp_err);
        check({tag, "_sop"}, lane, out_sop[lane], 1'b1);
        check({tag, "_eop"}, lane, out_eop[lane], 1'b1);
        done = 1'b0;
        k = 0;
        while (!done && k < 200) begin
            r = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            out_rdy[lane] = r;
            @(negedge clk);
            k++;
            if (r) begin
                done = 1'b1;
            end else begin
                check({tag, "_stall_val"}, lane, out_val[lane], 1'b1);
                check({tag, "_stall_dat"}, lane, out_dat[lane], v.exp_dat);
            end
        end
        check({tag, "_val_drop"}, lane, out_val[lane], 1'b0);
        out_rdy[lane] = 1'b0;
    endtask

    task automatic run_all(input vec_t v, input bit rand_rdy, input string tag);
        fork
            run_op(0, v, rand_rdy, tag);
            run_op(1, v, rand_rdy, tag);
            run_op(2, v, rand_rdy, tag);
        join
    endtask

    initial begin
        vec_t         tbl [7];
        vec_t         v;
        logic [255:0] a;
        logic [255:0] ones;
        logic         e;
        bit           stale;

        ones = '1;
        tbl[0] = mk(MONT_R_MODP,  8'h5A, 1'b0, 256'd1,                1'b0);
        tbl[1] = mk(MONT_R2_MODP, 8'h11, 1'b0, MONT_R_MODP,           1'b0);
        tbl[2] = mk(256'd0,       8'h22, 1'b0, 256'd0,                1'b0);
        tbl[3] = mk(P,            8'h33, 1'b0, 256'd0,                1'b1);
        tbl[4] = mk(ones,         8'h44, 1'b0, fe_from_mont(ones),    1'b1);
        tbl[5] = mk(P - 256'd1,   8'h55, 1'b0, fe_from_mont(P - 256'd1), 1'b0);
        tbl[6] = mk(256'd5,       8'hA5, 1'b1, fe_from_mont(256'd5),  1'b1);

        rst_n   = 1'b0;
        in_val  = '0;
        in_dat  = '0;
        in_ctl  = '0;
        in_err  = '0;
        out_rdy = '0;

        repeat (3) @(negedge clk);
        for (int l = 0; l < LANES; l++) begin
            check("rst_out_val", l, out_val[l], 1'b0);
            check("rst_out_dat", l, out_dat[l], 256'd0);
            check("rst_out_ctl", l, out_ctl[l], 8'd0);
            check("rst_out_err", l, out_err[l], 1'b0);
            check("rst_out_sop", l, out_sop[l], 1'b0);
            check("rst_out_eop", l, out_eop[l], 1'b0);
            check("rst_in_rdy",  l, in_rdy[l],  1'b0);
        end
        rst_n = 1'b1;
        #1;
        for (int l = 0; l < LANES; l++) check("release_rdy_before_edge", l, in_rdy[l], 1'b0);
        @(negedge clk);
        for (int l = 0; l < LANES; l++) check("release_rdy_after_edge", l, in_rdy[l], 1'b1);

        for (int i = 0; i < 7; i++) run_all(tbl[i], 1'b0, $sformatf("vec%0d", i));

        // Reset in the middle of RUN on every lane: nothing may come out afterwards.
        @(negedge clk);
        for (int l = 0; l < LANES; l++) begin
            in_val[l] = 1'b1;
            in_dat[l] = MONT_R2_MODP;
            in_ctl[l] = 8'h77;
            in_err[l] = 1'b0;
        end
        @(negedge clk);
        in_val = '0;
        for (int l = 0; l < LANES; l++) check("midrst_accepted", l, in_rdy[l], 1'b0);
        repeat (50) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        for (int l = 0; l < LANES; l++) begin
            check("midrst_out_val", l, out_val[l], 1'b0);
            check("midrst_in_rdy",  l, in_rdy[l],  1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stale = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (out_val != '0) stale = 1'b1;
        end
        check("midrst_no_stale_out", 0, stale, 1'b0);
        run_all(tbl[0], 1'b0, "post_rst");

        for (int i = 0; i < N_RAND; i++) begin
            for (int w = 0; w < 8; w++) a[w*32 +: 32] = $urandom;
            a = a % P;
            e = ($urandom_range(0, 7) == 0);
            v = mk(a, 8'(i), e, fe_from_mont(a), e);
            run_all(v, 1'b1, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end
endmodule
